// File: rtl/alu_mc_param.sv
// alu_mc_param: registered ALU with one-cycle logic/arith/shift ops and
// iterative multi-cycle MUL (shift-add) and DIVU/REMU (restoring division).
module alu_mc_param #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned SIGNED_LT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             zero,
    output logic             lt
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = SHW + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_REMU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SRL  = 4'b1110;
    localparam logic [3:0] OP_SLL  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] x_q, x_d;       // multiplicand / dividend-quotient shifter
    logic [WIDTH-1:0] y_q, y_d;       // multiplier / divisor
    logic [WIDTH-1:0] acc_q, acc_d;   // product accumulator / partial remainder
    logic             sc_q, sc_d;     // single-cycle op waiting to retire
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             lt_q, lt_d;

    logic             accept_c;
    logic             is_mul_c;
    logic             is_div_c;
    logic [WIDTH-1:0] sc_res_c;
    logic [WIDTH-1:0] fin_res_c;
    logic             lt_c;
    logic [WIDTH:0]   rem_sh_c;
    logic             div_ge_c;

    assign accept_c = start & ~busy_q;
    assign is_mul_c = (ALUOp == OP_MUL);
    assign is_div_c = (ALUOp == OP_DIVU) || (ALUOp == OP_REMU);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c && is_mul_c) begin
                    state_d = S_MUL;
                end else if (accept_c && is_div_c) begin
                    state_d = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One-cycle result from the captured operands
    always_comb begin
        sc_res_c = '0;
        case (op_q)
            OP_AND:  sc_res_c = a_q & b_q;
            OP_OR:   sc_res_c = a_q | b_q;
            OP_ADD:  sc_res_c = a_q + b_q;
            OP_SUB:  sc_res_c = a_q - b_q;
            OP_NOR:  sc_res_c = ~(a_q | b_q);
            OP_SLL:  sc_res_c = a_q << b_q[SHW-1:0];
            OP_SRL:  sc_res_c = a_q >> b_q[SHW-1:0];
            default: sc_res_c = '0;
        endcase
    end

    // Comparison of the captured operands, signedness fixed by parameter
    always_comb begin
        if (SIGNED_LT != 0) begin
            lt_c = $signed(a_q) < $signed(b_q);
        end else begin
            lt_c = a_q < b_q;
        end
    end

    // Restoring-division step and final multi-cycle result selection
    always_comb begin
        rem_sh_c  = {acc_q, x_q[WIDTH-1]};
        div_ge_c  = rem_sh_c >= {1'b0, y_q};
        fin_res_c = (op_q == OP_DIVU) ? x_q : acc_q;
    end

    // Datapath and registered outputs
    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        x_d    = x_q;
        y_d    = y_q;
        acc_d  = acc_q;
        sc_d   = 1'b0;
        done_d = 1'b0;
        res_d  = res_q;
        zero_d = zero_q;
        lt_d   = lt_q;

        if (accept_c) begin
            op_d  = ALUOp;
            a_d   = a;
            b_d   = b;
            x_d   = a;
            y_d   = b;
            acc_d = '0;
            cnt_d = '0;
            sc_d  = ~(is_mul_c | is_div_c);
        end

        case (state_q)
            S_MUL: begin
                acc_d = acc_q + (y_q[0] ? x_q : '0);
                x_d   = x_q << 1;
                y_d   = y_q >> 1;
                cnt_d = cnt_q + CW'(1);
            end
            S_DIV: begin
                if (div_ge_c) begin
                    acc_d = WIDTH'(rem_sh_c - {1'b0, y_q});
                    x_d   = {x_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh_c[WIDTH-1:0];
                    x_d   = {x_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
            end
            S_FIN: begin
                done_d = 1'b1;
                res_d  = fin_res_c;
                zero_d = (fin_res_c == '0);
                lt_d   = lt_c;
            end
            default: ;
        endcase

        if (sc_q) begin
            done_d = 1'b1;
            res_d  = sc_res_c;
            zero_d = (sc_res_c == '0);
            lt_d   = lt_c;
        end

        busy_d = (state_d != S_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            acc_q  <= '0;
            sc_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res_q  <= '0;
            zero_q <= 1'b1;
            lt_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            x_q    <= x_d;
            y_q    <= y_d;
            acc_q  <= acc_d;
            sc_q   <= sc_d;
            busy_q <= busy_d;
            done_q <= done_d;
            res_q  <= res_d;
            zero_q <= zero_d;
            lt_q   <= lt_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Result = res_q;
    assign zero   = zero_q;
    assign lt     = lt_q;

endmodule

// File: tb/tb_alu_mc_param.sv
// Testbench for alu_mc_param: vector table, hand sequences, random vs model.
module tb_alu_mc_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  alu_op;
    logic [63:0] a, b;
    logic        busy, done, zero, lt;
    logic [63:0] result;
    logic        busy_s, done_s, zero_s, lt_s;
    logic [63:0] result_s;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_mc_param #(.WIDTH(64), .SIGNED_LT(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUOp(alu_op), .a(a), .b(b),
        .busy(busy), .done(done), .Result(result), .zero(zero), .lt(lt)
    );

    alu_mc_param #(.WIDTH(64), .SIGNED_LT(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUOp(alu_op), .a(a), .b(b),
        .busy(busy_s), .done(done_s), .Result(result_s), .zero(zero_s), .lt(lt_s)
    );

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        lt_u;
        logic        lt_s;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural reference: plain arithmetic on the operation's definition
    function automatic logic [63:0] model_res(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        case (op)
            4'd0:  return x & y;
            4'd1:  return x | y;
            4'd2:  return x + y;
            4'd6:  return x - y;
            4'd12: return ~(x | y);
            4'd15: return x << (y % 64);
            4'd14: return x >> (y % 64);
            4'd3:  return x * y;
            4'd4:  return (y == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : x / y;
            4'd5:  return (y == 0) ? x : x % y;
            default: return 64'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op);
        return (op == 4'd3 || op == 4'd4 || op == 4'd5) ? 65 : 1;
    endfunction

    // Issue one op at posedge+1 and wait (bounded) for done; scribble inputs while waiting
    task automatic do_op(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                         input int poke, output int lat, output int busy_bad, output int hold_bad);
        logic [63:0] prev;
        logic        exp_busy;
        int          n;
        exp_busy = (model_lat(op) > 1);
        start = 1'b1; alu_op = op; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        prev = result;
        busy_bad = 0; hold_bad = 0; n = 0;
        do begin
            if (busy !== exp_busy) busy_bad++;
            if (result !== prev) hold_bad++;
            start  = (n == poke);
            alu_op = start ? 4'd2 : 4'($urandom);
            a      = {$urandom, $urandom};
            b      = {$urandom, $urandom};
            @(posedge clk); #1;
            n++;
        end while (!done && n < 200);
        start = 1'b0;
        lat = n;
    endtask

    task automatic run_check(input string name, input logic [3:0] op, input logic [63:0] x,
                             input logic [63:0] y, input logic [63:0] er, input logic elt,
                             input logic elts, input int elat, input int poke);
        int lat, bb, hb;
        do_op(op, x, y, poke, lat, bb, hb);
        check({name, ".latency"}, 64'(lat), 64'(elat));
        check({name, ".result"}, result, er);
        check({name, ".zero"}, 64'(zero), 64'(er == 64'd0));
        check({name, ".lt"}, 64'(lt), 64'(elt));
        check({name, ".lt_signed"}, 64'(lt_s), 64'(elts));
        check({name, ".busy_at_done"}, 64'(busy), 64'd0);
        if (elat > 1) begin
            check({name, ".busy_while_running"}, 64'(bb), 64'd0);
            check({name, ".result_held"}, 64'(hb), 64'd0);
        end
    endtask

    initial begin
        vec_t vecs[$];
        int   done_seen;
        logic [3:0]  rop;
        logic [63:0] ra, rb;
        logic [3:0]  ops[10];

        vecs.push_back('{4'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b1, 1});
        vecs.push_back('{4'd15, 64'd1, 64'h41, 64'd2, 1'b1, 1'b1, 1});
        vecs.push_back('{4'd14, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0, 1'b1, 1});
        vecs.push_back('{4'd3,  64'h1_0000_0001, 64'd3, 64'h3_0000_0003, 1'b0, 1'b0, 65});
        vecs.push_back('{4'd4,  64'd100, 64'd7, 64'd14, 1'b0, 1'b0, 65});
        vecs.push_back('{4'd5,  64'd100, 64'd7, 64'd2, 1'b0, 1'b0, 65});
        vecs.push_back('{4'd4,  64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 65});
        vecs.push_back('{4'd5,  64'd100, 64'd0, 64'd100, 1'b0, 1'b0, 65});
        vecs.push_back('{4'd6,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1});
        vecs.push_back('{4'd7,  64'd5, 64'd9, 64'd0, 1'b1, 1'b1, 1});
        vecs.push_back('{4'd0,  64'hF0F0, 64'h0FF0, 64'h00F0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd1,  64'hF0F0, 64'h0FF0, 64'hFFF0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd12, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd0,  64'hF0, 64'h0F, 64'd0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd6,  64'd5, 64'd5, 64'd0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd2,  64'd2, 64'd3, 64'd5, 1'b1, 1'b1, 1});

        rst_n = 1'b0; start = 1'b1; alu_op = 4'd2; a = 64'd7; b = 64'd9;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.result", result, 64'd0);
        check("reset.zero", 64'(zero), 64'd1);
        check("reset.lt", 64'(lt), 64'd0);
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset.done", 64'(done), 64'd0);

        // Directed vector table
        foreach (vecs[i])
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].res, vecs[i].lt_u, vecs[i].lt_s, vecs[i].lat, -1);

        // MUL with a start pulse mid-operation: must be ignored
        run_check("mul_poke", 4'd3, 64'h1_0000_0001, 64'd3, 64'h3_0000_0003, 1'b0, 1'b0, 65, 10);
        @(posedge clk); #1;
        check("mul_poke.no_extra_done", 64'(done), 64'd0);

        // Back-to-back single-cycle ops: done on consecutive cycles
        start = 1'b1; alu_op = 4'd2; a = 64'd1; b = 64'd2;
        @(posedge clk); #1;
        alu_op = 4'd1; a = 64'hC; b = 64'd3;
        @(posedge clk); #1;
        check("b2b.done0", 64'(done), 64'd1);
        check("b2b.res0", result, 64'd3);
        alu_op = 4'd15; a = 64'd1; b = 64'd4;
        @(posedge clk); #1;
        check("b2b.done1", 64'(done), 64'd1);
        check("b2b.res1", result, 64'hF);
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b.done2", 64'(done), 64'd1);
        check("b2b.res2", result, 64'd16);
        @(posedge clk); #1;
        check("b2b.idle", 64'(done), 64'd0);

        // Multi-cycle op followed by a start issued in its done cycle
        run_check("mul_then", 4'd3, 64'd6, 64'd7, 64'd42, 1'b1, 1'b1, 65, -1);
        run_check("add_in_done_cycle", 4'd2, 64'd2, 64'd2, 64'd4, 1'b0, 1'b0, 1, -1);

        // Reset ten cycles into a MUL: abort, no done, clean restart
        run_check("pre_abort", 4'd4, 64'd100, 64'd7, 64'd14, 1'b0, 1'b0, 65, -1);
        start = 1'b1; alu_op = 4'd3; a = 64'd5; b = 64'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.result", result, 64'd0);
        check("abort.zero", 64'(zero), 64'd1);
        check("abort.done", 64'(done), 64'd0);
        start = 1'b1; alu_op = 4'd3;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; start = 1'b0;
        done_seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("abort.no_done", 64'(done_seen), 64'd0);
        run_check("abort.add", 4'd2, 64'd2, 64'd3, 64'd5, 1'b1, 1'b1, 1, -1);

        // Random operations against the reference model
        ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd12, 4'd15, 4'd14, 4'd3, 4'd4, 4'd5};
        for (int k = 0; k < 50; k++) begin
            rop = ops[$urandom_range(0, 9)];
            if (($urandom % 8) == 0) rop = 4'($urandom_range(7, 11));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (($urandom % 3) == 0) rb = 64'($urandom_range(0, 300));
            if (($urandom % 4) == 0) ra = 64'($urandom_range(0, 1000));
            run_check($sformatf("rand%0d", k), rop, ra, rb, model_res(rop, ra, rb),
                      ra < rb, $signed(ra) < $signed(rb), model_lat(rop), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
